bram_delay_ctrl: RTL and testbench

BRAM_DELAY_CTRL -- requirements
Module: bram_delay_ctrl

---
 rtl/bram_ctrl_pkg.sv | 25 ++
 rtl/bram_sp_be.sv | 33 +++
 rtl/bram_delay_ctrl.sv | 145 ++++++++++++++
 tb/tb_bram_delay_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_ctrl_pkg.sv
// Shared definitions for the delayed block-RAM controller: default sizing,
// the request opcode type and the width helpers used for derived ports.
package bram_ctrl_pkg;

  localparam int DEF_ADDR_W  = 13;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_LATENCY = 10;
  localparam int DEF_N_REQ   = 3;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  // Width of the requester tag; a single requester still gets a 1-bit tag.
  function automatic int tag_width(input int n_req);
    return (n_req <= 1) ? 1 : $clog2(n_req);
  endfunction

  // Width of the in-flight counter, sized to hold LATENCY+1 without overflow.
  function automatic int inflight_width(input int latency);
    return $clog2(latency + 2);
  endfunction

endpackage

// File: rtl/bram_sp_be.sv
// Single-port, byte-enabled block RAM with a one-cycle registered read.
// A read-first port: the read data of an access reflects the array before
// any write performed on the same edge.
module bram_sp_be
  import bram_ctrl_pkg::*;
#(
  parameter int  ADDR_W = DEF_ADDR_W,
  parameter int  DATA_W = DEF_DATA_W,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic [STRB_W-1:0] we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Byte-masked write and registered read, both only when the port is enabled.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (we[b]) begin
          mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/bram_delay_ctrl.sv
// Block-RAM controller that delays every request by a fixed number of cycles
// before it reaches the array, then returns read data to the owning requester
// one cycle after the array access. No backpressure: one request per cycle.
module bram_delay_ctrl
  import bram_ctrl_pkg::*;
#(
  parameter int  ADDR_W  = DEF_ADDR_W,
  parameter int  DATA_W  = DEF_DATA_W,
  parameter int  LATENCY = DEF_LATENCY,
  parameter int  N_REQ   = DEF_N_REQ,
  localparam int TAG_W   = tag_width(N_REQ),
  localparam int CNT_W   = inflight_width(LATENCY),
  localparam int STRB_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic [TAG_W-1:0]  tag,
  output logic [DATA_W-1:0] rdata,
  output logic [N_REQ-1:0]  rd_valid,
  output logic [CNT_W-1:0]  inflight,
  output logic              idle
);

  typedef struct packed {
    op_e               op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic [TAG_W-1:0]  tag;
  } req_t;

  req_t               in_req;
  logic [LATENCY-1:0] pipe_vld;
  req_t               pipe_req [LATENCY];

  req_t               arr_req;
  logic               arr_en;
  logic               arr_is_wr;
  logic               arr_is_rd;
  logic [STRB_W-1:0]  arr_we;
  logic [DATA_W-1:0]  arr_rdata;

  logic               rd_pend;
  logic [TAG_W-1:0]   rd_tag_q;
  logic [CNT_W-1:0]   inflight_nxt;

  // Pack the incoming request fields into one pipeline word.
  always_comb begin
    in_req       = '0;
    in_req.op    = wr ? OP_WRITE : OP_READ;
    in_req.addr  = addr;
    in_req.wdata = wdata;
    in_req.wstrb = wstrb;
    in_req.tag   = tag;
  end

  // Valid bits are the only pipeline state cleared by reset, so a reset discards all in-flight work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= in_valid;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
      end
    end
  end

  // Payload shifts unconditionally; it is meaningless wherever the matching valid bit is low.
  always_ff @(posedge clk) begin
    pipe_req[0] <= in_req;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_req[i] <= pipe_req[i-1];
    end
  end

  // The last pipeline stage drives the array on the edge LATENCY cycles after acceptance.
  always_comb begin
    arr_req   = pipe_req[LATENCY-1];
    arr_en    = pipe_vld[LATENCY-1];
    arr_is_wr = arr_en && (arr_req.op == OP_WRITE);
    arr_is_rd = arr_en && (arr_req.op == OP_READ);
    arr_we    = arr_is_wr ? arr_req.wstrb : '0;
  end

  bram_sp_be #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (arr_we),
    .addr  (arr_req.addr),
    .wdata (arr_req.wdata),
    .rdata (arr_rdata)
  );

  // Remember that the array performed a read this cycle, and for whom.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend  <= 1'b0;
      rd_tag_q <= '0;
    end else begin
      rd_pend  <= arr_is_rd;
      rd_tag_q <= arr_req.tag;
    end
  end

  // Capture array data only when a read retires, and pulse the owner's one-hot valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata    <= '0;
      rd_valid <= '0;
    end else begin
      if (rd_pend) begin
        rdata <= arr_rdata;
      end
      for (int i = 0; i < N_REQ; i++) begin
        rd_valid[i] <= rd_pend && (rd_tag_q == TAG_W'(i));
      end
    end
  end

  // Writes retire on their array cycle and reads on their rd_valid cycle, so two can retire at once.
  always_comb begin
    inflight_nxt = inflight + CNT_W'(in_valid) - CNT_W'(arr_is_wr) - CNT_W'(rd_pend);
  end

  // Occupancy counter of accepted but not yet retired requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      inflight <= inflight_nxt;
    end
  end

  assign idle = (inflight == '0);

endmodule

// File: tb/tb_bram_delay_ctrl.sv
// Directed self-checking bench for bram_delay_ctrl. Three instances share one
// stimulus stream: the default build (LATENCY=10) plus LATENCY=1 and 32 builds.
module tb_bram_delay_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        wr;
  logic [12:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [1:0]  tag;

  logic [31:0] rdata;
  logic [2:0]  rd_valid;
  logic [3:0]  inflight;
  logic        idle;

  logic [31:0] rdata_l1;
  logic [2:0]  rd_valid_l1;
  logic [1:0]  inflight_l1;
  logic        idle_l1;

  logic [31:0] rdata_l32;
  logic [2:0]  rd_valid_l32;
  logic [5:0]  inflight_l32;
  logic        idle_l32;

  int checks = 0;
  int errors = 0;
  int pulses;
  int exp_inf;
  int acc;
  int ret;
  int j;

  bram_delay_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .wr       (wr),
    .addr     (addr),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .tag      (tag),
    .rdata    (rdata),
    .rd_valid (rd_valid),
    .inflight (inflight),
    .idle     (idle)
  );

  bram_delay_ctrl #(.LATENCY(1)) dut_l1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .wr       (wr),
    .addr     (addr),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .tag      (tag),
    .rdata    (rdata_l1),
    .rd_valid (rd_valid_l1),
    .inflight (inflight_l1),
    .idle     (idle_l1)
  );

  bram_delay_ctrl #(.LATENCY(32)) dut_l32 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .wr       (wr),
    .addr     (addr),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .tag      (tag),
    .rdata    (rdata_l32),
    .rd_valid (rd_valid_l32),
    .inflight (inflight_l32),
    .idle     (idle_l32)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one request (or an idle slot) at a falling edge and wait until the
  // next falling edge, so exactly one rising edge samples it.
  task automatic applyStimulus(input logic v, input logic w, input logic [12:0] a,
                               input logic [31:0] d, input logic [3:0] s, input logic [1:0] t);
    in_valid = v;
    wr       = w;
    addr     = a;
    wdata    = d;
    wstrb    = s;
    tag      = t;
    @(negedge clk);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 13'h0, 32'h0, 4'h0, 2'd0);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, observed, expected);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    wr       = 1'b0;
    addr     = '0;
    wdata    = '0;
    wstrb    = '0;
    tag      = '0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset_rd_valid", 64'(rd_valid), 64'h0);
    checkOutput("reset_rdata",    64'(rdata),    64'h0);
    checkOutput("reset_inflight", 64'(inflight), 64'h0);
    checkOutput("reset_idle",     64'(idle),     64'h1);
    rst_n = 1'b1;
    idleCycle();

    // Write then read the same address one cycle later; read retires 11 edges after acceptance
    $display("[TB] write/read 0x005");
    applyStimulus(1'b1, 1'b1, 13'h005, 32'hDEADBEEF, 4'hF, 2'd0);
    checkOutput("t1_inflight_e0", 64'(inflight), 64'd1);
    checkOutput("t1_idle_e0",     64'(idle),     64'd0);
    applyStimulus(1'b1, 1'b0, 13'h005, 32'h0, 4'h0, 2'd1);
    checkOutput("t1_inflight_e1", 64'(inflight), 64'd2);
    for (int k = 2; k <= 13; k++) begin
      idleCycle();
      checkOutput("t1_rd_valid", 64'(rd_valid), (k == 12) ? 64'h2 : 64'h0);
      exp_inf = (k < 10) ? 2 : ((k < 12) ? 1 : 0);
      checkOutput("t1_inflight", 64'(inflight), 64'(exp_inf));
      if (k == 11) checkOutput("t1_rdata_before", 64'(rdata), 64'h0);
      if (k == 12) checkOutput("t1_rdata", 64'(rdata), 64'hDEADBEEF);
    end
    checkOutput("t1_idle_end", 64'(idle), 64'h1);

    // Byte-enabled write over a known value
    $display("[TB] byte strobes");
    applyStimulus(1'b1, 1'b1, 13'h009, 32'hAAAAAAAA, 4'hF, 2'd0);
    applyStimulus(1'b1, 1'b1, 13'h009, 32'h11223344, 4'b0101, 2'd0);
    applyStimulus(1'b1, 1'b0, 13'h009, 32'h0, 4'h0, 2'd0);
    for (int k = 3; k <= 14; k++) begin
      idleCycle();
      checkOutput("t2_rd_valid", 64'(rd_valid), (k == 13) ? 64'h1 : 64'h0);
      if (k == 12) checkOutput("t2_rdata_held", 64'(rdata), 64'hDEADBEEF);
      if (k == 13) checkOutput("t2_rdata", 64'(rdata), 64'hAA22AA44);
    end

    // Read before a write returns old data, read after it returns new data
    $display("[TB] program order");
    applyStimulus(1'b1, 1'b0, 13'h009, 32'h0, 4'h0, 2'd2);
    applyStimulus(1'b1, 1'b1, 13'h009, 32'h55555555, 4'hF, 2'd0);
    applyStimulus(1'b1, 1'b0, 13'h009, 32'h0, 4'h0, 2'd0);
    for (int k = 3; k <= 14; k++) begin
      idleCycle();
      checkOutput("t3_rd_valid", 64'(rd_valid), (k == 11) ? 64'h4 : ((k == 13) ? 64'h1 : 64'h0));
      if (k == 11 || k == 12) checkOutput("t3_rdata_old", 64'(rdata), 64'hAA22AA44);
      if (k == 13) checkOutput("t3_rdata_new", 64'(rdata), 64'h55555555);
    end
    checkOutput("t3_inflight_end", 64'(inflight), 64'h0);
    idleCycle();
    idleCycle();
    checkOutput("t3_idle", 64'(idle), 64'h1);

    // 40 back-to-back reads, tags cycling 0,1,2, alternating addresses 0x005/0x009
    $display("[TB] back-to-back reads");
    pulses = 0;
    for (int k = 0; k <= 51; k++) begin
      if (k < 40) applyStimulus(1'b1, 1'b0, (k % 2 == 0) ? 13'h005 : 13'h009, 32'h0, 4'h0, 2'(k % 3));
      else idleCycle();
      acc = (k < 40) ? k + 1 : 40;
      ret = (k - 10 < 0) ? 0 : ((k - 10 > 40) ? 40 : k - 10);
      exp_inf = acc - ret;
      checkOutput("t4_inflight", 64'(inflight), 64'(exp_inf));
      if (k >= 11 && k <= 50) begin
        j = k - 11;
        checkOutput("t4_rd_valid", 64'(rd_valid), 64'(1 << (j % 3)));
        checkOutput("t4_rdata", 64'(rdata), (j % 2 == 0) ? 64'hDEADBEEF : 64'h55555555);
      end else begin
        checkOutput("t4_rd_valid_quiet", 64'(rd_valid), 64'h0);
      end
      if (rd_valid != 3'b000) pulses++;
    end
    checkOutput("t4_pulse_count", 64'(pulses), 64'd40);

    // Out-of-range tag: no valid pulse, still retires
    $display("[TB] out-of-range tag");
    applyStimulus(1'b1, 1'b0, 13'h005, 32'h0, 4'h0, 2'd3);
    checkOutput("t5_inflight_e0", 64'(inflight), 64'd1);
    for (int k = 1; k <= 12; k++) begin
      idleCycle();
      checkOutput("t5_rd_valid", 64'(rd_valid), 64'h0);
      if (k == 10) checkOutput("t5_inflight_e10", 64'(inflight), 64'd1);
      if (k == 11) checkOutput("t5_inflight_e11", 64'(inflight), 64'd0);
    end
    checkOutput("t5_idle", 64'(idle), 64'h1);

    // Reset with a write and 5 reads in flight
    $display("[TB] mid-operation reset");
    applyStimulus(1'b1, 1'b1, 13'h009, 32'h12345678, 4'hF, 2'd0);
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b0, 13'h005, 32'h0, 4'h0, 2'(k % 3));
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checkOutput("t6_idle_async",     64'(idle),     64'h1);
    checkOutput("t6_inflight_async", 64'(inflight), 64'h0);
    checkOutput("t6_rdata_async",    64'(rdata),    64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      idleCycle();
      checkOutput("t6_rd_valid_quiet", 64'(rd_valid), 64'h0);
      checkOutput("t6_inflight_quiet", 64'(inflight), 64'h0);
    end
    applyStimulus(1'b1, 1'b0, 13'h009, 32'h0, 4'h0, 2'd1);
    for (int k = 1; k <= 11; k++) idleCycle();
    checkOutput("t6_rd_valid_after", 64'(rd_valid), 64'h2);
    checkOutput("t6_write_dropped",  64'(rdata),    64'h55555555);

    // Latency of the 1- and 32-stage builds
    $display("[TB] latency builds");
    repeat (30) idleCycle();
    checkOutput("t7_l32_idle_pre", 64'(inflight_l32), 64'h0);
    for (int k = 0; k <= 34; k++) begin
      if (k == 0) applyStimulus(1'b1, 1'b0, 13'h005, 32'h0, 4'h0, 2'd2);
      else idleCycle();
      checkOutput("t7_l1_rd_valid",  64'(rd_valid_l1),  (k == 2)  ? 64'h4 : 64'h0);
      checkOutput("t7_l32_rd_valid", 64'(rd_valid_l32), (k == 33) ? 64'h4 : 64'h0);
      checkOutput("t7_l10_rd_valid", 64'(rd_valid),     (k == 11) ? 64'h4 : 64'h0);
      if (k == 0)  checkOutput("t7_l32_inflight", 64'(inflight_l32), 64'd1);
      if (k == 1)  checkOutput("t7_l1_inflight",  64'(inflight_l1),  64'd1);
      if (k == 2)  checkOutput("t7_l1_rdata",     64'(rdata_l1),     64'hDEADBEEF);
      if (k == 2)  checkOutput("t7_l1_idle",      64'(idle_l1),      64'h1);
      if (k == 33) checkOutput("t7_l32_rdata",    64'(rdata_l32),    64'hDEADBEEF);
    end
    checkOutput("t7_l32_idle", 64'(idle_l32), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
